score_judge: RTL and testbench
==============================

SCORE_JUDGE -- requirements
Module: score_judge

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning the number of arrow columns judged.
REQ-002 SHALL have parameter MAX_MISS, default 3, meaning the miss count that ends the game.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port is10, input, 1, the one-cycle step tick shared with the light rows.
REQ-006 SHALL have port start, input, 1, a one-cycle start/restart request.
REQ-007 SHALL have port lightOn, input, LANES, the bottom-row light of each column.
REQ-008 SHALL have port pressed, input, LANES, the bottom-row press of each column (key AND lit).
REQ-009 SHALL have port score, output, 16, a 4-digit BCD score, digit 3 in bits 15:12.
REQ-010 SHALL have port combo, output, 7, a binary current streak, 0..99.
REQ-011 SHALL have port missCnt, output, 2 (clog2(MAX_MISS+1)), the misses this game.
REQ-012 SHALL have port playing, output, 1, high in state PLAY.
REQ-013 SHALL have port gameOver, output, 1, high in state OVER.
REQ-014 SHALL have port hitPulse, output, 1, high for one cycle after a step that scored at least one hit.

Function
REQ-015 SHALL implement an FSM with states IDLE, PLAY and OVER: IDLE->PLAY on start; PLAY->OVER on the cycle the registered missCnt reaches MAX_MISS; OVER->IDLE on start; all other conditions hold the current state.
REQ-016 SHALL, on IDLE->PLAY, clear score, combo, missCnt and all hit latches in the same edge.
REQ-017 SHALL keep a per-lane hit latch in PLAY: set on pressed[i]&lightOn[i], cleared on every is10 cycle.
REQ-018 SHALL treat a press coincident with is10 as a hit for the step being closed: hit[i] = lightOn[i] & (latch[i] | pressed[i]).
REQ-019 SHALL, on is10 in PLAY, set hits = popcount(hit) and misses = popcount(lightOn & ~hit); the results are visible on outputs the following cycle (1-cycle latency).
REQ-020 SHALL add hits to score in BCD, saturating at 9999 (example: 9998+2 gives 9999).
REQ-021 SHALL, when misses>0, zero combo and add misses to missCnt, saturating at MAX_MISS; otherwise combo += hits, saturating at 99.
REQ-022 SHALL leave score, combo and missCnt unchanged on a step with no lit lane.
REQ-023 SHALL ignore is10, pressed and lightOn in IDLE and OVER; counters hold their final values in OVER.
REQ-024 SHALL assert hitPulse for exactly the cycle after an is10 step with hits>0 in PLAY.
REQ-025 SHALL let start in PLAY have no effect.

Reset
REQ-026 SHALL, on Reset, go to IDLE, set score=0, combo=0, missCnt=0, hitPulse=0 and clear all latches, including mid-step and mid-game; Reset overrides start and is10 in the same cycle.
REQ-027 SHALL drive outputs after reset as playing=0 and gameOver=0.

Structure
REQ-028 SHALL place the state enum (IDLE/PLAY/OVER), BCD_MAX=16'h9999 and COMBO_MAX=99 in shared package ddr_pkg.
REQ-029 SHALL implement the 4-digit saturating BCD adder (16-bit BCD plus 0..LANES) as sub-module bcd_sat_add; the rest stays in score_judge.

Verification
REQ-030 SHALL cover: start, then lightOn=0001, pressed=0001 for 3 cycles, then is10 -> next cycle score=0001, combo=1, hitPulse=1 for one cycle.
REQ-031 SHALL cover: lightOn=0011, pressed=0001 only, then is10 -> score +1, combo=0, missCnt=1.
REQ-032 SHALL cover: score preloaded to 9998 via hits, then a 2-hit step -> score=9999, and 9999 holds on later hits.
REQ-033 SHALL cover: three single-miss steps -> missCnt=3, gameOver=1, and further is10/pressed leave score unchanged; start -> IDLE, and start again -> counters cleared.
REQ-034 SHALL cover: pressed coincident with is10 -> counted as a hit; press in the cycle after is10 -> counted in the next step.
REQ-035 SHALL cover: Reset asserted mid-step with a latch set -> next cycle all outputs 0, state IDLE, and the latch does not count after restart.

Source files
------------

// File: rtl/ddr_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pkg -- shared definitions for the dance-pad scoring slice.
//
// Contents:
//   state_t    game FSM states (IDLE, PLAY, OVER)
//   BCD_MAX    saturation value of the 4-digit BCD score (9999)
//   COMBO_MAX  saturation value of the binary combo streak (99)
//   bcd_digits number of BCD digits carried by the score
// ---------------------------------------------------------------------------
package ddr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam int          BCD_DIGITS = 4;
   localparam logic [15:0] BCD_MAX    = 16'h9999;
   localparam logic [6:0]  COMBO_MAX  = 7'd99;

endpackage : ddr_pkg

// File: rtl/bcd_sat_add.sv
// ---------------------------------------------------------------------------
// bcd_sat_add -- adds a small binary increment to a 4-digit packed BCD value,
// saturating at 9999.
//
// Parameters:
//   INC_W  width of the binary increment
//
// Ports:
//   a    input  [15:0]       current BCD value (digit 3 in bits 15:12)
//   inc  input  [INC_W-1:0]  binary amount to add
//   sum  output [15:0]       a + inc in BCD, clamped to BCD_MAX
//
// The increment is injected as the carry into digit 0 and rippled upward;
// each digit keeps (digit + carry) mod 10 and passes the quotient on. A
// carry left over past digit 3 means the result exceeded 9999.
// ---------------------------------------------------------------------------
module bcd_sat_add
   import ddr_pkg::*;
#(
   parameter int INC_W = 3
) (
   input  logic [15:0]      a,
   input  logic [INC_W-1:0] inc,
   output logic [15:0]      sum
);

   logic [15:0] raw;
   int          carry;
   int          t;

   always_comb begin
      // NOTE: every variable written here gets a default before any
      // conditional or loop touches it, so no latch can be inferred.
      raw   = '0;
      carry = int'(inc);
      t     = 0;
      for (int d = 0; d < BCD_DIGITS; d++) begin
         t                = int'(a[4*d +: 4]) + carry;
         raw[4*d +: 4]    = 4'(t % 10);
         carry            = t / 10;
      end
      sum = (carry != 0) ? BCD_MAX : raw;
   end

endmodule : bcd_sat_add

// File: rtl/score_judge.sv
// ---------------------------------------------------------------------------
// score_judge -- judges the bottom row of a rhythm game and keeps score.
//
// Parameters:
//   LANES     number of arrow columns judged
//   MAX_MISS  miss count that ends the game
//
// Ports:
//   clk       input   1                     system clock, rising edge
//   Reset     input   1                     synchronous, active-high
//   is10      input   1                     one-cycle step tick
//   start     input   1                     one-cycle start/restart request
//   lightOn   input   LANES                 bottom-row light per column
//   pressed   input   LANES                 bottom-row press per column
//   score     output  16                    4-digit BCD score
//   combo     output  7                     binary streak, 0..99
//   missCnt   output  clog2(MAX_MISS+1)     misses this game
//   playing   output  1                     high in PLAY
//   gameOver  output  1                     high in OVER
//   hitPulse  output  1                     one cycle after a step with hits
//
// Between ticks each lit column remembers whether it was pressed (hit
// latch). On the tick the step is closed: a lit column counts as a hit if
// it was latched or is pressed right now, otherwise as a miss. Results land
// on the outputs one cycle later.
// ---------------------------------------------------------------------------
module score_judge
   import ddr_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int MAX_MISS = 3
) (
   input  logic                         clk,
   input  logic                         Reset,
   input  logic                         is10,
   input  logic                         start,
   input  logic [LANES-1:0]             lightOn,
   input  logic [LANES-1:0]             pressed,
   output logic [15:0]                  score,
   output logic [6:0]                   combo,
   output logic [$clog2(MAX_MISS+1)-1:0] missCnt,
   output logic                         playing,
   output logic                         gameOver,
   output logic                         hitPulse
);

   localparam int HW = $clog2(LANES + 1);
   localparam int MW = $clog2(MAX_MISS + 1);
   // Wide enough to hold missCnt + misses without wrapping.
   localparam int SW = ((MW > HW) ? MW : HW) + 1;

   localparam logic [MW-1:0] MISS_LIMIT = MW'(MAX_MISS);

   state_t            state;
   logic [LANES-1:0]  latch;

   logic [LANES-1:0]  hit_vec;
   logic [LANES-1:0]  miss_vec;
   logic [HW-1:0]     hits;
   logic [HW-1:0]     misses;
   logic [15:0]       score_sum;
   logic [7:0]        combo_sum;
   logic [6:0]        combo_next;
   logic [SW-1:0]     miss_sum;
   logic [MW-1:0]     miss_next;

   // ------------------------------------------------------------------
   // Step judgement: a press arriving together with the tick still counts
   // for the step being closed.
   // ------------------------------------------------------------------
   always_comb begin
      hit_vec  = lightOn & (latch | pressed);
      miss_vec = lightOn & ~hit_vec;
      hits     = '0;
      misses   = '0;
      for (int i = 0; i < LANES; i++) begin
         hits   = hits   + HW'(hit_vec[i]);
         misses = misses + HW'(miss_vec[i]);
      end
   end

   bcd_sat_add #(
      .INC_W (HW)
   ) u_add (
      .a   (score),
      .inc (hits),
      .sum (score_sum)
   );

   // Any miss breaks the streak; otherwise the streak grows by the hits.
   // A step with no lit column gives hits = misses = 0 and changes nothing.
   always_comb begin
      combo_sum = {1'b0, combo} + 8'(hits);
      if (misses != '0) begin
         combo_next = '0;
      end else if (combo_sum > {1'b0, COMBO_MAX}) begin
         combo_next = COMBO_MAX;
      end else begin
         combo_next = combo_sum[6:0];
      end

      miss_sum = SW'(missCnt) + SW'(misses);
      if (miss_sum >= SW'(MAX_MISS)) begin
         miss_next = MISS_LIMIT;
      end else begin
         miss_next = miss_sum[MW-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Game FSM, counters and registered status outputs.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: all state uses non-blocking assignments so every register
      // updates from values sampled before this edge.
      if (Reset) begin
         state    <= IDLE;
         score    <= '0;
         combo    <= '0;
         missCnt  <= '0;
         latch    <= '0;
         hitPulse <= 1'b0;
         playing  <= 1'b0;
         gameOver <= 1'b0;
      end else begin
         hitPulse <= 1'b0;
         case (state)
            IDLE: begin
               // Counters keep the last game's values until a new start.
               latch <= '0;
               if (start) begin
                  state    <= PLAY;
                  playing  <= 1'b1;
                  gameOver <= 1'b0;
                  score    <= '0;
                  combo    <= '0;
                  missCnt  <= '0;
               end
            end

            PLAY: begin
               if (is10) begin
                  latch    <= '0;
                  score    <= score_sum;
                  combo    <= combo_next;
                  missCnt  <= miss_next;
                  hitPulse <= (hits != '0);
               end else begin
                  latch <= latch | (pressed & lightOn);
               end
               // Game ends once the registered miss count is at the limit.
               if (missCnt == MISS_LIMIT) begin
                  state    <= OVER;
                  playing  <= 1'b0;
                  gameOver <= 1'b1;
                  latch    <= '0;
               end
            end

            OVER: begin
               latch <= '0;
               if (start) begin
                  state    <= IDLE;
                  gameOver <= 1'b0;
               end
            end

            default: begin
               state    <= IDLE;
               playing  <= 1'b0;
               gameOver <= 1'b0;
               latch    <= '0;
            end
         endcase
      end
   end

endmodule : score_judge

// File: tb/tb_score_judge.sv
// ---------------------------------------------------------------------------
// tb_score_judge -- self-checking bench for score_judge (LANES=4,
// MAX_MISS=3). Each vector holds the inputs for one clock cycle and the
// outputs expected just after that cycle's rising edge.
// ---------------------------------------------------------------------------
module tb_score_judge;

   logic        clk = 1'b0;
   logic        Reset;
   logic        is10;
   logic        start;
   logic [3:0]  lightOn;
   logic [3:0]  pressed;
   logic [15:0] score;
   logic [6:0]  combo;
   logic [1:0]  missCnt;
   logic        playing;
   logic        gameOver;
   logic        hitPulse;

   score_judge #(
      .LANES    (4),
      .MAX_MISS (3)
   ) dut (
      .clk      (clk),
      .Reset    (Reset),
      .is10     (is10),
      .start    (start),
      .lightOn  (lightOn),
      .pressed  (pressed),
      .score    (score),
      .combo    (combo),
      .missCnt  (missCnt),
      .playing  (playing),
      .gameOver (gameOver),
      .hitPulse (hitPulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        st;
      logic        tick;
      logic [3:0]  lit;
      logic [3:0]  prs;
      logic [15:0] score;
      int          combo;
      int          miss;
      logic        pulse;
      logic        play;
      logic        over;
      logic        chk_state;
   } vec_t;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t expq[$];
   vec_t tbl[25];

   function automatic vec_t mk(input logic rst, input logic st, input logic tick,
                               input logic [3:0] lit, input logic [3:0] prs,
                               input logic [15:0] sc, input int cb, input int ms,
                               input logic pulse, input logic play,
                               input logic over, input logic chk_state);
      vec_t v;
      v.rst = rst;  v.st = st;  v.tick = tick;  v.lit = lit;  v.prs = prs;
      v.score = sc; v.combo = cb; v.miss = ms;  v.pulse = pulse;
      v.play = play; v.over = over; v.chk_state = chk_state;
      return v;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, and compare once
   // the edge has produced the DUT's response.
   task automatic apply(input vec_t v, input string tag);
      vec_t e;
      Reset   = v.rst;
      start   = v.st;
      is10    = v.tick;
      lightOn = v.lit;
      pressed = v.prs;
      expq.push_back(v);
      @(posedge clk);
      #1;
      e = expq.pop_front();
      check({tag, " score"},    32'(score),    32'(e.score));
      check({tag, " combo"},    32'(combo),    32'(e.combo));
      check({tag, " missCnt"},  32'(missCnt),  32'(e.miss));
      check({tag, " hitPulse"}, 32'(hitPulse), 32'(e.pulse));
      if (e.chk_state) begin
         check({tag, " playing"},  32'(playing),  32'(e.play));
         check({tag, " gameOver"}, 32'(gameOver), 32'(e.over));
      end
   endtask

   initial begin
      int sc;
      int cb;

      Reset = 1'b1; start = 1'b0; is10 = 1'b0; lightOn = '0; pressed = '0;

      //              rst st tk lit    prs    score    cb ms pl py ov chk
      tbl[0]  = mk(1, 0, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 0, 0, 1); // reset state
      tbl[1]  = mk(0, 1, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 1, 0, 1); // start
      tbl[2]  = mk(0, 0, 0, 4'h1, 4'h1, 16'h0000, 0, 0, 0, 1, 0, 1); // press x3
      tbl[3]  = mk(0, 0, 0, 4'h1, 4'h1, 16'h0000, 0, 0, 0, 1, 0, 1);
      tbl[4]  = mk(0, 0, 0, 4'h1, 4'h1, 16'h0000, 0, 0, 0, 1, 0, 1);
      tbl[5]  = mk(0, 0, 1, 4'h1, 4'h0, 16'h0001, 1, 0, 1, 1, 0, 1); // latched hit
      tbl[6]  = mk(0, 0, 0, 4'h0, 4'h0, 16'h0001, 1, 0, 0, 1, 0, 1); // pulse drops
      tbl[7]  = mk(0, 0, 0, 4'h3, 4'h1, 16'h0001, 1, 0, 0, 1, 0, 1); // one of two
      tbl[8]  = mk(0, 0, 1, 4'h3, 4'h0, 16'h0002, 0, 1, 1, 1, 0, 1); // hit + miss
      tbl[9]  = mk(0, 0, 0, 4'h0, 4'h0, 16'h0002, 0, 1, 0, 1, 0, 1);
      tbl[10] = mk(0, 0, 1, 4'h4, 4'h4, 16'h0003, 1, 1, 1, 1, 0, 1); // press on tick
      tbl[11] = mk(0, 0, 0, 4'h4, 4'h4, 16'h0003, 1, 1, 0, 1, 0, 1); // press after tick
      tbl[12] = mk(0, 0, 1, 4'h4, 4'h0, 16'h0004, 2, 1, 1, 1, 0, 1); // counted next step
      tbl[13] = mk(0, 0, 1, 4'h4, 4'h0, 16'h0004, 0, 2, 0, 1, 0, 1); // latch was cleared
      tbl[14] = mk(0, 0, 1, 4'h0, 4'h0, 16'h0004, 0, 2, 0, 1, 0, 1); // nothing lit
      tbl[15] = mk(0, 1, 0, 4'h0, 4'h0, 16'h0004, 0, 2, 0, 1, 0, 1); // start in PLAY
      tbl[16] = mk(0, 0, 1, 4'h8, 4'h0, 16'h0004, 0, 3, 0, 0, 0, 0); // third miss
      tbl[17] = mk(0, 0, 0, 4'h0, 4'h0, 16'h0004, 0, 3, 0, 0, 1, 1); // game over
      tbl[18] = mk(0, 0, 1, 4'hF, 4'hF, 16'h0004, 0, 3, 0, 0, 1, 1); // ignored in OVER
      tbl[19] = mk(0, 1, 0, 4'h0, 4'h0, 16'h0004, 0, 3, 0, 0, 0, 1); // to IDLE, hold
      tbl[20] = mk(0, 1, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 1, 0, 1); // restart clears
      tbl[21] = mk(0, 0, 0, 4'h1, 4'h1, 16'h0000, 0, 0, 0, 1, 0, 1); // latch set
      tbl[22] = mk(1, 1, 1, 4'h1, 4'h1, 16'h0000, 0, 0, 0, 0, 0, 1); // reset wins
      tbl[23] = mk(0, 1, 0, 4'h0, 4'h0, 16'h0000, 0, 0, 0, 1, 0, 1); // restart
      tbl[24] = mk(0, 0, 1, 4'h1, 4'h0, 16'h0000, 0, 1, 0, 1, 0, 1); // old latch gone

      for (int i = 0; i < 25; i++) begin
         apply(tbl[i], $sformatf("vec%0d", i));
      end

      // Score preload: 2499 four-hit steps (presses coincident with the tick)
      // reach 9996, then a two-hit step reaches 9998.
      sc = 0;
      cb = 0;
      for (int k = 0; k < 2499; k++) begin
         sc = sc + 4;
         cb = (cb + 4 > 99) ? 99 : cb + 4;
         apply(mk(0, 0, 1, 4'hF, 4'hF, to_bcd(sc), cb, 1, 1, 1, 0, 1),
               $sformatf("preload%0d", k));
      end
      apply(mk(0, 0, 1, 4'h3, 4'h3, 16'h9998, 99, 1, 1, 1, 0, 1), "to9998");
      apply(mk(0, 0, 1, 4'h3, 4'h3, 16'h9999, 99, 1, 1, 1, 0, 1), "sat9999");
      apply(mk(0, 0, 1, 4'h1, 4'h1, 16'h9999, 99, 1, 1, 1, 0, 1), "hold9999");

      // Four misses on top of one: missCnt clamps at 3, then the game ends.
      apply(mk(0, 0, 1, 4'hF, 4'h0, 16'h9999, 0, 3, 0, 1, 0, 0), "misssat");
      apply(mk(0, 0, 0, 4'h0, 4'h0, 16'h9999, 0, 3, 0, 0, 1, 1), "over2");
      apply(mk(0, 0, 1, 4'h2, 4'h2, 16'h9999, 0, 3, 0, 0, 1, 1), "overhold");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_score_judge
